trap_sequencer: RTL and testbench

Sits directly downstream of the interrupt controller and exception handler. Consumes their request/vector outputs, arbitrates between them, and sequences trap entry:
- flushes and drains the pipeline, saves EPC/cause/tval, and redirects fetch to the vector.
It also sequences trap return, restoring state from a small nesting stack. Final stage before the fetch-PC mux.

---
 rtl/trap_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_trap_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// Trap entry/return sequencer: accept -> DRAIN (pipe_flush) -> REDIRECT; return -> RETURN; min entry latency accept+2.
// Requests outside IDLE are ignored (sources hold level). Define TRAP_DRAIN_TIMEOUT_EN to bound DRAIN by DRAIN_TIMEOUT cycles.
module trap_sequencer #(
   parameter int ADDR_W        = 48,
   parameter int NEST_DEPTH    = 4,
   parameter int DRAIN_TIMEOUT = 15
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic                          i_exception_request,
   input  logic [4:0]                    i_exception_vector,
   input  logic [ADDR_W-1:0]             i_exception_pc,
   input  logic [ADDR_W-1:0]             i_faulting_addr,
   input  logic                          i_interrupt_pending,
   input  logic [4:0]                    i_interrupt_vector,
   output logic                          o_interrupt_ack,
   input  logic [ADDR_W-1:0]             i_trap_base,
   input  logic                          i_trap_return,
   input  logic                          i_int_enable_we,
   input  logic                          i_int_enable_wd,
   output logic                          o_int_enable,
   output logic                          o_pipe_flush,
   input  logic                          i_pipe_drained,
   output logic                          o_redirect_valid,
   output logic [ADDR_W-1:0]             o_redirect_pc,
   output logic [ADDR_W-1:0]             o_epc,
   output logic [31:0]                   o_cause,
   output logic [ADDR_W-1:0]             o_tval,
   output logic [$clog2(NEST_DEPTH):0]   o_nest_level,
   output logic                          o_nest_overflow,
   output logic                          o_drain_timeout,
   output logic                          o_busy
);

   localparam int LVL_W = $clog2(NEST_DEPTH) + 1;
   localparam int IDX_W = $clog2(NEST_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_REDIRECT, S_RETURN} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                w_take_exc;
   logic                w_take_int;
   logic                w_take_ret;
   logic                w_take_we;
   logic                w_timeout_hit;
   logic                w_full;
   logic [LVL_W-1:0]    w_pop_lvl;
   logic [IDX_W-1:0]    w_push_idx;
   logic [IDX_W-1:0]    w_pop_idx;
   logic [ADDR_W-1:0]   w_vec_off;

   logic                r_int_enable;
   logic [ADDR_W-1:0]   r_epc;
   logic [31:0]         r_cause;
   logic [ADDR_W-1:0]   r_tval;
   logic [LVL_W-1:0]    r_nest_level;
   logic                r_nest_overflow;
   logic [ADDR_W-1:0]   r_redirect_pc;

   logic [ADDR_W-1:0]   r_stk_epc   [NEST_DEPTH];
   logic [31:0]         r_stk_cause [NEST_DEPTH];
   logic [ADDR_W-1:0]   r_stk_tval  [NEST_DEPTH];
   logic                r_stk_ie    [NEST_DEPTH];

   assign w_full     = (r_nest_level == LVL_W'(NEST_DEPTH));
   assign w_pop_lvl  = r_nest_level - LVL_W'(1);
   assign w_push_idx = r_nest_level[IDX_W-1:0];
   assign w_pop_idx  = w_pop_lvl[IDX_W-1:0];
   assign w_vec_off  = {{(ADDR_W-9){1'b0}}, r_cause[4:0], 4'b0000};

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_take_exc       = 1'b0;
      w_take_int       = 1'b0;
      w_take_ret       = 1'b0;
      w_take_we        = 1'b0;
      o_interrupt_ack  = 1'b0;
      o_pipe_flush     = 1'b0;
      o_redirect_valid = 1'b0;
      o_busy           = (r_state != S_IDLE);
      case (r_state)
         S_IDLE: begin
            // Strict priority; anything lower in the same cycle is dropped.
            if (i_exception_request)                         w_take_exc = 1'b1;
            else if (i_interrupt_pending && r_int_enable)    w_take_int = 1'b1;
            else if (i_trap_return && r_nest_level != '0)    w_take_ret = 1'b1;
            else if (i_int_enable_we)                        w_take_we  = 1'b1;
            if (w_take_exc || w_take_int) w_state_nxt = S_DRAIN;
            else if (w_take_ret)          w_state_nxt = S_RETURN;
            o_interrupt_ack = w_take_int && !i_reset;
         end
         S_DRAIN: begin
            o_pipe_flush = 1'b1;
            if (i_pipe_drained || w_timeout_hit) w_state_nxt = S_REDIRECT;
         end
         S_REDIRECT, S_RETURN: begin
            o_redirect_valid = 1'b1;
            w_state_nxt      = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_int_enable    <= 1'b0;
         r_epc           <= '0;
         r_cause         <= '0;
         r_tval          <= '0;
         r_nest_level    <= '0;
         r_nest_overflow <= 1'b0;
         r_redirect_pc   <= '0;
         for (int i = 0; i < NEST_DEPTH; i++) begin
            r_stk_epc[i]   <= '0;
            r_stk_cause[i] <= '0;
            r_stk_tval[i]  <= '0;
            r_stk_ie[i]    <= 1'b0;
         end
      end else begin
         if (w_take_exc || w_take_int) begin
            r_epc        <= i_exception_pc;
            r_int_enable <= 1'b0;
            r_tval       <= w_take_exc ? i_faulting_addr : '0;
            if (w_full) begin
               // Double fault: context of the deepest trap is overwritten, not saved.
               r_nest_overflow <= 1'b1;
               r_cause         <= 32'h1F;
            end else begin
               r_cause <= w_take_exc ? {27'b0, i_exception_vector}
                                     : {1'b1, 26'b0, i_interrupt_vector};
               r_stk_epc[w_push_idx]   <= r_epc;
               r_stk_cause[w_push_idx] <= r_cause;
               r_stk_tval[w_push_idx]  <= r_tval;
               r_stk_ie[w_push_idx]    <= r_int_enable;
               r_nest_level            <= r_nest_level + LVL_W'(1);
            end
         end
         if (w_take_ret) begin
            r_redirect_pc <= r_epc;
            r_nest_level  <= w_pop_lvl;
            r_int_enable  <= r_stk_ie[w_pop_idx];
            if (r_nest_level == LVL_W'(1)) begin
               r_epc   <= '0;
               r_cause <= '0;
               r_tval  <= '0;
            end else begin
               r_epc   <= r_stk_epc[w_pop_idx];
               r_cause <= r_stk_cause[w_pop_idx];
               r_tval  <= r_stk_tval[w_pop_idx];
            end
         end
         if (w_take_we) r_int_enable <= i_int_enable_wd;
         if (r_state == S_DRAIN && w_state_nxt == S_REDIRECT)
            r_redirect_pc <= i_trap_base + w_vec_off;
      end
   end

`ifdef TRAP_DRAIN_TIMEOUT_EN
   localparam int CNT_W = $clog2(DRAIN_TIMEOUT + 1);
   logic [CNT_W-1:0] r_drain_cnt;
   logic             r_drain_timeout;

   // Count reads 0 in the first DRAIN cycle, so the last permitted cycle holds DRAIN_TIMEOUT-1.
   assign w_timeout_hit = (r_state == S_DRAIN) && !i_pipe_drained &&
                          (r_drain_cnt == CNT_W'(DRAIN_TIMEOUT - 1));

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_drain_cnt     <= '0;
         r_drain_timeout <= 1'b0;
      end else begin
         if (r_state == S_DRAIN) r_drain_cnt <= r_drain_cnt + CNT_W'(1);
         else                    r_drain_cnt <= '0;
         if (w_timeout_hit) r_drain_timeout <= 1'b1;
      end
   end
   assign o_drain_timeout = r_drain_timeout;
`else
   assign w_timeout_hit   = 1'b0;
   assign o_drain_timeout = 1'b0;
`endif

   assign o_int_enable    = r_int_enable;
   assign o_redirect_pc   = r_redirect_pc;
   assign o_epc           = r_epc;
   assign o_cause         = r_cause;
   assign o_tval          = r_tval;
   assign o_nest_level    = r_nest_level;
   assign o_nest_overflow = r_nest_overflow;

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: directed scenarios plus random traffic against a queue-based context model.
module tb_trap_sequencer;
   localparam int AW = 48;
   localparam int ND = 4;
   localparam int DT = 15;
`ifdef TRAP_DRAIN_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst, exc_req, int_pend, tret, we, wd, drained;
   logic [4:0]    exc_vec, int_vec;
   logic [AW-1:0] exc_pc, faddr, base;
   logic          ack, ie, flush, rv, ovf, dto, busy;
   logic [AW-1:0] rpc, epc, tval;
   logic [31:0]   cause;
   logic [2:0]    nest;

   always #5 clk = ~clk;

   trap_sequencer #(.ADDR_W(AW), .NEST_DEPTH(ND), .DRAIN_TIMEOUT(DT)) dut (
      .i_clk(clk), .i_reset(rst),
      .i_exception_request(exc_req), .i_exception_vector(exc_vec),
      .i_exception_pc(exc_pc), .i_faulting_addr(faddr),
      .i_interrupt_pending(int_pend), .i_interrupt_vector(int_vec),
      .o_interrupt_ack(ack), .i_trap_base(base), .i_trap_return(tret),
      .i_int_enable_we(we), .i_int_enable_wd(wd), .o_int_enable(ie),
      .o_pipe_flush(flush), .i_pipe_drained(drained),
      .o_redirect_valid(rv), .o_redirect_pc(rpc), .o_epc(epc), .o_cause(cause),
      .o_tval(tval), .o_nest_level(nest), .o_nest_overflow(ovf),
      .o_drain_timeout(dto), .o_busy(busy));

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference model: architectural context plus a queue of saved contexts.
   typedef struct {
      logic [AW-1:0] epc;
      logic [31:0]   cause;
      logic [AW-1:0] tval;
      logic          ie;
   } ctx_t;

   ctx_t          m_cur;
   ctx_t          m_stack[$];
   bit            m_wait, m_pulse, m_ovf, m_dto;
   int            m_drain_n;
   logic [AW-1:0] m_rpc;

   task automatic model_update();
      ctx_t nc;
      ctx_t sv;
      if (rst) begin
         m_cur = '{default: 0};
         m_stack.delete();
         m_wait = 0; m_pulse = 0; m_ovf = 0; m_dto = 0; m_drain_n = 0; m_rpc = '0;
         return;
      end
      if (m_pulse) begin
         m_pulse = 0;
      end else if (m_wait) begin
         m_drain_n++;
         if (drained || (TO_EN && m_drain_n == DT)) begin
            if (!drained) m_dto = 1;
            m_wait  = 0;
            m_pulse = 1;
            m_rpc   = base + (AW'(m_cur.cause[4:0]) << 4);
         end
      end else if (exc_req || (int_pend && m_cur.ie)) begin
         nc.epc   = exc_pc;
         nc.ie    = 1'b0;
         nc.tval  = exc_req ? faddr : '0;
         nc.cause = exc_req ? {27'b0, exc_vec} : (32'h8000_0000 | {27'b0, int_vec});
         if (m_stack.size() == ND) begin
            m_ovf    = 1;
            nc.cause = 32'h1F;
         end else begin
            m_stack.push_back(m_cur);
         end
         m_cur = nc;
         m_wait = 1;
         m_drain_n = 0;
      end else if (tret && m_stack.size() > 0) begin
         sv = m_stack.pop_back();
         m_rpc = m_cur.epc;
         if (m_stack.size() == 0) begin
            m_cur = '{default: 0};
            m_cur.ie = sv.ie;
         end else begin
            m_cur = sv;
         end
         m_pulse = 1;
      end else if (we) begin
         m_cur.ie = wd;
      end
   endtask

   // One clock: compare all outputs with the model, advance the model, move to next negedge.
   task automatic step();
      logic exp_ack;
      #1;
      exp_ack = !rst && !m_wait && !m_pulse && !exc_req && int_pend && m_cur.ie;
      chk("ack", ack, exp_ack);
      chk("redirect_valid", rv, m_pulse);
      chk("redirect_pc", rpc, m_rpc);
      chk("pipe_flush", flush, m_wait);
      chk("busy", busy, m_wait || m_pulse);
      chk("int_enable", ie, m_cur.ie);
      chk("epc", epc, m_cur.epc);
      chk("cause", cause, m_cur.cause);
      chk("tval", tval, m_cur.tval);
      chk("nest_level", nest, m_stack.size());
      chk("nest_overflow", ovf, m_ovf);
      chk("drain_timeout", dto, m_dto);
      model_update();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clr();
      exc_req = 0; int_pend = 0; tret = 0; we = 0; wd = 0; rst = 0;
   endtask

   task automatic do_reset();
      clr();
      rst = 1;
      model_update();
      @(posedge clk);
      @(negedge clk);
      rst = 0;
   endtask

   task automatic raise_exc(input logic [4:0] v, input logic [AW-1:0] pc, input logic [AW-1:0] fa);
      exc_req = 1; exc_vec = v; exc_pc = pc; faddr = fa;
      step();
      exc_req = 0;
   endtask

   task automatic do_ret();
      tret = 1;
      step();
      tret = 0;
   endtask

   task automatic chk_all_zero(input string tag);
      #1;
      chk({tag, "_ack"}, ack, 0);   chk({tag, "_rv"}, rv, 0);
      chk({tag, "_rpc"}, rpc, 0);   chk({tag, "_flush"}, flush, 0);
      chk({tag, "_busy"}, busy, 0); chk({tag, "_ie"}, ie, 0);
      chk({tag, "_epc"}, epc, 0);   chk({tag, "_cause"}, cause, 0);
      chk({tag, "_tval"}, tval, 0); chk({tag, "_nest"}, nest, 0);
      chk({tag, "_ovf"}, ovf, 0);   chk({tag, "_dto"}, dto, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, n_total=%0d", n_total);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] r64;
      int k;
      clr();
      exc_vec = 0; int_vec = 0; exc_pc = 0; faddr = 0; base = 0; drained = 1;
      @(negedge clk);
      do_reset();
      chk_all_zero("reset");

      // Exception path
      base = 48'h8000; drained = 1;
      raise_exc(5'd6, 48'h1000, 48'hDEAD);
      chk("exc_cause", cause, 32'h6);   chk("exc_epc", epc, 48'h1000);
      chk("exc_tval", tval, 48'hDEAD);  chk("exc_nest", nest, 1);
      chk("exc_ie", ie, 0);             chk("exc_rv_early", rv, 0);
      step();
      chk("exc_rv", rv, 1);             chk("exc_rpc", rpc, 48'h8060);
      step();
      chk("exc_rv_once", rv, 0);

      // Interrupt masking, then software enable
      int_pend = 1; int_vec = 5'd3; exc_pc = 48'h2000;
      for (int i = 0; i < 3; i++) begin
         #1; chk("masked_ack", ack, 0);
         step();
      end
      we = 1; wd = 1;
      step();
      we = 0; wd = 0;
      #1; chk("unmasked_ack", ack, 1);
      step();
      #1; chk("ack_pulse_end", ack, 0);
      int_pend = 0;
      chk("int_cause", cause, 32'h8000_0003); chk("int_tval", tval, 0);
      chk("int_nest", nest, 2);
      step();
      chk("int_rv", rv, 1);             chk("int_rpc", rpc, 48'h8030);
      step();
      do_ret();
      chk("ret1_rv", rv, 1);            chk("ret1_rpc", rpc, 48'h2000);
      chk("ret1_nest", nest, 1);        chk("ret1_cause", cause, 32'h6);
      chk("ret1_ie", ie, 1);
      step();

      // Exception, interrupt and return in the same cycle at nest level 1
      exc_req = 1; exc_vec = 5'd2; exc_pc = 48'h3000; faddr = 48'h33;
      int_pend = 1; int_vec = 5'd9; tret = 1;
      #1; chk("simul_ack", ack, 0);
      step();
      clr();
      chk("simul_nest", nest, 2);       chk("simul_cause", cause, 32'h2);
      chk("simul_rv", rv, 0);
      step();
      chk("simul_rpc", rpc, 48'h8020);
      step();
      do_ret();
      chk("simul_ret_rpc", rpc, 48'h3000);
      step();
      do_ret();
      chk("simul_ret2_rpc", rpc, 48'h1000); chk("simul_ret2_ie", ie, 0);
      step();

      // Nesting and unwind with interrupts enabled
      do_reset();
      we = 1; wd = 1;
      step();
      clr();
      raise_exc(5'd1, 48'h100, 48'h0); step(); step();
      raise_exc(5'd1, 48'h200, 48'h0); step(); step();
      chk("nest2", nest, 2);
      do_ret();
      chk("unwind1_rpc", rpc, 48'h200); chk("unwind1_nest", nest, 1);
      step();
      do_ret();
      chk("unwind2_rpc", rpc, 48'h100); chk("unwind2_nest", nest, 0);
      chk("unwind2_ie", ie, 1);
      step();
      do_ret();
      chk("ret_lvl0_rv", rv, 0);        chk("ret_lvl0_busy", busy, 0);
      step();

      // Double fault
      do_reset();
      for (int i = 0; i < ND; i++) begin
         raise_exc(5'(i + 1), AW'(48'h1000 + i * 16), AW'(i));
         step(); step();
      end
      chk("pre_df_ovf", ovf, 0);
      raise_exc(5'd7, 48'h5000, 48'h55);
      step();
      chk("df_ovf", ovf, 1);            chk("df_cause", cause, 32'h1F);
      chk("df_nest", nest, ND);         chk("df_rpc", rpc, 48'h81F0);
      step();

      // Drain wait / timeout
      do_reset();
      drained = 0;
      raise_exc(5'd4, 48'h4000, 48'h44);
      if (TO_EN) begin
         k = 0;
         while (!rv && k < 40) begin
            step();
            k++;
         end
         chk("to_latency", k, DT);
         chk("to_rv", rv, 1);           chk("to_flag", dto, 1);
         chk("to_rpc", rpc, 48'h8040);
         step();
      end else begin
         for (int i = 0; i < 20; i++) begin
            #1; chk("wait_flush", flush, 1); chk("wait_rv", rv, 0);
            step();
         end
         drained = 1;
         step();
         chk("wait_rv_after", rv, 1);   chk("wait_dto", dto, 0);
         step();
      end
      drained = 0;
      raise_exc(5'd5, 48'h6000, 48'h66);
      step(); step();
      do_reset();
      chk_all_zero("drain_reset");

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         exc_req  = ($urandom_range(0, 7) == 0);
         int_pend = ($urandom_range(0, 3) == 0);
         tret     = ($urandom_range(0, 3) == 0);
         we       = ($urandom_range(0, 4) == 0);
         wd       = $urandom_range(0, 1);
         drained  = ($urandom_range(0, 2) != 0);
         rst      = ($urandom_range(0, 199) == 0);
         exc_vec  = 5'($urandom);
         int_vec  = 5'($urandom);
         r64 = {$urandom, $urandom}; exc_pc = r64[AW-1:0];
         r64 = {$urandom, $urandom}; faddr  = r64[AW-1:0];
         r64 = {$urandom, $urandom}; base   = r64[AW-1:0];
         step();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
